// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fixed-priority ST>LD>IF memory arbiter with IF starvation guard and flush squash.
// Optional MEM_ARB_STATS_EN adds grant and busy-cycle counters.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  output logic        if_req_ready,
  output logic        if_resp_valid,
  output logic [31:0] if_resp_data,
  input  logic        ld_req_valid,
  input  logic [31:0] ld_req_addr,
  input  logic [1:0]  ld_req_size,
  output logic        ld_req_ready,
  output logic        ld_resp_valid,
  output logic [31:0] ld_resp_data,
  input  logic        st_req_valid,
  input  logic [31:0] st_req_addr,
  input  logic [1:0]  st_req_size,
  input  logic [31:0] st_req_data,
  output logic        st_req_ready,
  output logic        st_done,
  output logic        m_req_valid,
  output logic        m_req_wr,
  output logic [31:0] m_req_addr,
  output logic [1:0]  m_req_size,
  output logic [31:0] m_req_wdata,
  input  logic        m_req_ready,
  input  logic        m_resp_valid,
  input  logic [31:0] m_resp_data
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0] stat_if_grants,
  output logic [31:0] stat_ld_grants,
  output logic [31:0] stat_st_grants,
  output logic [31:0] stat_busy_cycles
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {OWN_IF, OWN_LD, OWN_ST} owner_t;

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q, data_d;
  logic        squash_q, squash_d;
  logic [CNT_W-1:0] starve_q, starve_d;

  logic if_win, ld_win, st_win, any_win;
  logic owner_cancellable;

  function automatic logic [1:0] fwd_size(input logic [1:0] s);
    return (s == 2'd3) ? 2'd2 : s;
  endfunction

  function automatic logic [31:0] size_mask(input logic [1:0] s, input logic [31:0] d);
    case (s)
      2'd0:    return {24'd0, d[7:0]};
      2'd1:    return {16'd0, d[15:0]};
      default: return d;
    endcase
  endfunction

  // A saturated starvation counter lets a waiting IF jump ahead of ST and LD.
  always_comb begin
    if_win = 1'b0;
    ld_win = 1'b0;
    st_win = 1'b0;
    if (state_q == S_IDLE && rdy && !rst) begin
      if (if_req_valid && !flush && starve_q == CNT_W'(STARVE_LIMIT)) begin
        if_win = 1'b1;
      end else if (st_req_valid) begin
        st_win = 1'b1;
      end else if (ld_req_valid && !flush) begin
        ld_win = 1'b1;
      end else if (if_req_valid && !flush) begin
        if_win = 1'b1;
      end
    end
  end

  assign any_win           = if_win | ld_win | st_win;
  assign if_req_ready      = if_win;
  assign ld_req_ready      = ld_win;
  assign st_req_ready      = st_win;
  assign owner_cancellable = (owner_q != OWN_ST);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    size_d   = size_q;
    wdata_d  = wdata_q;
    data_d   = data_q;
    squash_d = squash_q;
    starve_d = starve_q;
    if (rdy) begin
      if (!if_req_valid || if_win) begin
        starve_d = '0;
      end else if ((st_win || ld_win) && starve_q != CNT_W'(STARVE_LIMIT)) begin
        starve_d = starve_q + CNT_W'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (any_win) begin
            state_d  = S_ISSUE;
            squash_d = 1'b0;
            if (st_win) begin
              owner_d = OWN_ST;
              addr_d  = st_req_addr;
              size_d  = fwd_size(st_req_size);
              wdata_d = st_req_data;
            end else if (ld_win) begin
              owner_d = OWN_LD;
              addr_d  = ld_req_addr;
              size_d  = fwd_size(ld_req_size);
              wdata_d = '0;
            end else begin
              owner_d = OWN_IF;
              addr_d  = if_req_addr;
              size_d  = 2'd2;
              wdata_d = '0;
            end
          end
        end
        S_ISSUE: begin
          if (flush && owner_cancellable) squash_d = 1'b1;
          if (m_req_ready) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (flush && owner_cancellable) squash_d = 1'b1;
          if (m_resp_valid) begin
            data_d  = size_mask(size_q, m_resp_data);
            state_d = S_RESP;
          end
        end
        default: begin
          state_d  = S_IDLE;
          squash_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_IF;
      addr_q   <= '0;
      size_q   <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
      squash_q <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      wdata_q  <= wdata_d;
      data_q   <= data_d;
      squash_q <= squash_d;
      starve_q <= starve_d;
    end
  end

  // Request fields are only driven while ISSUE holds them; a flush in RESP squashes at once.
  assign m_req_valid   = (state_q == S_ISSUE);
  assign m_req_wr      = m_req_valid && (owner_q == OWN_ST);
  assign m_req_addr    = m_req_valid ? addr_q  : '0;
  assign m_req_size    = m_req_valid ? size_q  : '0;
  assign m_req_wdata   = m_req_valid ? wdata_q : '0;
  assign if_resp_valid = (state_q == S_RESP) && (owner_q == OWN_IF) && !squash_q && !flush;
  assign ld_resp_valid = (state_q == S_RESP) && (owner_q == OWN_LD) && !squash_q && !flush;
  assign st_done       = (state_q == S_RESP) && (owner_q == OWN_ST);
  assign if_resp_data  = data_q;
  assign ld_resp_data  = data_q;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] if_grants_q, if_grants_d;
  logic [31:0] ld_grants_q, ld_grants_d;
  logic [31:0] st_grants_q, st_grants_d;
  logic [31:0] busy_q, busy_d;

  always_comb begin
    if_grants_d = if_grants_q + {31'd0, if_win};
    ld_grants_d = ld_grants_q + {31'd0, ld_win};
    st_grants_d = st_grants_q + {31'd0, st_win};
    busy_d      = busy_q + {31'd0, (rdy && state_q != S_IDLE)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_grants_q <= '0;
      ld_grants_q <= '0;
      st_grants_q <= '0;
      busy_q      <= '0;
    end else begin
      if_grants_q <= if_grants_d;
      ld_grants_q <= ld_grants_d;
      st_grants_q <= st_grants_d;
      busy_q      <= busy_d;
    end
  end

  assign stat_if_grants   = if_grants_q;
  assign stat_ld_grants   = ld_grants_q;
  assign stat_st_grants   = st_grants_q;
  assign stat_busy_cycles = busy_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic        if_req_valid, if_req_ready, if_resp_valid;
  logic [31:0] if_req_addr, if_resp_data;
  logic        ld_req_valid, ld_req_ready, ld_resp_valid;
  logic [31:0] ld_req_addr, ld_resp_data;
  logic [1:0]  ld_req_size;
  logic        st_req_valid, st_req_ready, st_done;
  logic [31:0] st_req_addr, st_req_data;
  logic [1:0]  st_req_size;
  logic        m_req_valid, m_req_wr, m_req_ready, m_resp_valid;
  logic [31:0] m_req_addr, m_req_wdata, m_resp_data;
  logic [1:0]  m_req_size;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_if_grants, stat_ld_grants, stat_st_grants, stat_busy_cycles;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .ld_req_valid(ld_req_valid), .ld_req_addr(ld_req_addr), .ld_req_size(ld_req_size),
    .ld_req_ready(ld_req_ready), .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
    .st_req_valid(st_req_valid), .st_req_addr(st_req_addr), .st_req_size(st_req_size),
    .st_req_data(st_req_data), .st_req_ready(st_req_ready), .st_done(st_done),
    .m_req_valid(m_req_valid), .m_req_wr(m_req_wr), .m_req_addr(m_req_addr),
    .m_req_size(m_req_size), .m_req_wdata(m_req_wdata), .m_req_ready(m_req_ready),
    .m_resp_valid(m_resp_valid), .m_resp_data(m_resp_data)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_if_grants(stat_if_grants), .stat_ld_grants(stat_ld_grants),
    .stat_st_grants(stat_st_grants), .stat_busy_cycles(stat_busy_cycles)
`endif
  );

  // Called just after a negedge in ISSUE; returns just after the negedge where RESP is visible.
  task automatic serve(input logic [31:0] d, input int lat);
    m_req_ready = 1'b1;
    @(negedge clk);
    m_req_ready = 1'b0;
    repeat (lat) @(negedge clk);
    m_resp_valid = 1'b1;
    m_resp_data  = d;
    @(negedge clk);
    m_resp_valid = 1'b0;
    m_resp_data  = '0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    if_req_valid = 0; if_req_addr = 0;
    ld_req_valid = 0; ld_req_addr = 0; ld_req_size = 0;
    st_req_valid = 0; st_req_addr = 0; st_req_size = 0; st_req_data = 0;
    m_req_ready = 0; m_resp_valid = 0; m_resp_data = 0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (m_req_valid !== 1'b0) begin failures++; $display("FAIL reset_m_req_valid got=%0b exp=0", m_req_valid); end
    checks++; if (m_req_addr !== 32'h0) begin failures++; $display("FAIL reset_m_req_addr got=%h exp=0", m_req_addr); end
    checks++; if ({if_resp_valid, ld_resp_valid, st_done} !== 3'b000) begin failures++; $display("FAIL reset_pulses got=%b exp=000", {if_resp_valid, ld_resp_valid, st_done}); end
    checks++; if (if_resp_data !== 32'h0) begin failures++; $display("FAIL reset_resp_data got=%h exp=0", if_resp_data); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_if_only;
    if_req_valid = 1'b1; if_req_addr = 32'h100;
    #1;
    checks++; if (if_req_ready !== 1'b1) begin failures++; $display("FAIL t1_if_ready got=%0b exp=1", if_req_ready); end
    @(negedge clk);
    if_req_valid = 1'b0;
    #1;
    checks++; if (m_req_valid !== 1'b1) begin failures++; $display("FAIL t1_m_req_valid got=%0b exp=1", m_req_valid); end
    checks++; if (m_req_addr !== 32'h100) begin failures++; $display("FAIL t1_m_req_addr got=%h exp=00000100", m_req_addr); end
    checks++; if ({m_req_wr, m_req_size} !== 3'b010) begin failures++; $display("FAIL t1_wr_size got=%b exp=010", {m_req_wr, m_req_size}); end
    serve(32'h00C0FFEE, 5);
    checks++; if (if_resp_valid !== 1'b1) begin failures++; $display("FAIL t1_resp_valid got=%0b exp=1", if_resp_valid); end
    checks++; if (if_resp_data !== 32'h00C0FFEE) begin failures++; $display("FAIL t1_resp_data got=%h exp=00c0ffee", if_resp_data); end
    @(negedge clk);
    #1;
    checks++; if (if_resp_valid !== 1'b0) begin failures++; $display("FAIL t1_single_pulse got=%0b exp=0", if_resp_valid); end
  endtask

  task automatic test_priority;
    st_req_valid = 1'b1; st_req_addr = 32'h40; st_req_size = 2'd2; st_req_data = 32'hDEADBEEF;
    ld_req_valid = 1'b1; ld_req_addr = 32'h80; ld_req_size = 2'd2;
    #1;
    checks++; if ({st_req_ready, ld_req_ready} !== 2'b10) begin failures++; $display("FAIL t2_st_over_ld got=%b exp=10", {st_req_ready, ld_req_ready}); end
    @(negedge clk);
    st_req_valid = 1'b0;
    #1;
    checks++; if ({m_req_wr, m_req_addr} !== {1'b1, 32'h40}) begin failures++; $display("FAIL t2_st_issue got=%b/%h exp=1/00000040", m_req_wr, m_req_addr); end
    checks++; if (m_req_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL t2_st_wdata got=%h exp=deadbeef", m_req_wdata); end
    serve(32'h0, 1);
    checks++; if ({st_done, ld_req_ready} !== 2'b10) begin failures++; $display("FAIL t2_st_done got=%b exp=10", {st_done, ld_req_ready}); end
    @(negedge clk);
    #1;
    checks++; if ({ld_req_ready, st_done} !== 2'b10) begin failures++; $display("FAIL t2_ld_next_idle got=%b exp=10", {ld_req_ready, st_done}); end
    @(negedge clk);
    ld_req_valid = 1'b0;
    #1;
    checks++; if ({m_req_wr, m_req_addr} !== {1'b0, 32'h80}) begin failures++; $display("FAIL t2_ld_issue got=%b/%h exp=0/00000080", m_req_wr, m_req_addr); end
    serve(32'h5555AAAA, 1);
    checks++; if ({ld_resp_valid, ld_resp_data} !== {1'b1, 32'h5555AAAA}) begin failures++; $display("FAIL t2_ld_resp got=%b/%h exp=1/5555aaaa", ld_resp_valid, ld_resp_data); end
    @(negedge clk);
  endtask

  task automatic test_starvation;
    if_req_addr = 32'hF00;
    for (int i = 0; i < 4; i++) begin
      if_req_valid = 1'b1;
      ld_req_valid = 1'b1; ld_req_addr = 32'h1000 + 32'(i * 4); ld_req_size = 2'd2;
      #1;
      checks++; if ({ld_req_ready, if_req_ready} !== 2'b10) begin failures++; $display("FAIL t3_ld_wins_%0d got=%b exp=10", i, {ld_req_ready, if_req_ready}); end
      @(negedge clk);
      ld_req_valid = 1'b0;
      #1;
      serve(32'(i), 0);
      @(negedge clk);
    end
    ld_req_valid = 1'b1;
    #1;
    checks++; if ({if_req_ready, ld_req_ready} !== 2'b10) begin failures++; $display("FAIL t3_if_wins_5th got=%b exp=10", {if_req_ready, ld_req_ready}); end
    @(negedge clk);
    if_req_valid = 1'b0; ld_req_valid = 1'b0;
    #1;
    checks++; if (m_req_addr !== 32'hF00) begin failures++; $display("FAIL t3_if_addr got=%h exp=00000f00", m_req_addr); end
    serve(32'h1234, 0);
    checks++; if (if_resp_valid !== 1'b1) begin failures++; $display("FAIL t3_if_resp got=%0b exp=1", if_resp_valid); end
    @(negedge clk);
  endtask

  task automatic test_sizes;
    logic [1:0]  sz [3]   = '{2'd0, 2'd1, 2'd3};
    logic [1:0]  fsz [3]  = '{2'd0, 2'd1, 2'd2};
    logic [31:0] ad [3]   = '{32'h2001, 32'h2002, 32'h2004};
    logic [31:0] exp [3]  = '{32'h000000DD, 32'h0000CCDD, 32'hAABBCCDD};
    for (int i = 0; i < 3; i++) begin
      ld_req_valid = 1'b1; ld_req_addr = ad[i]; ld_req_size = sz[i];
      @(negedge clk);
      ld_req_valid = 1'b0;
      #1;
      checks++; if ({m_req_addr, m_req_size} !== {ad[i], fsz[i]}) begin failures++; $display("FAIL t4_req_%0d got=%h/%0d exp=%h/%0d", i, m_req_addr, m_req_size, ad[i], fsz[i]); end
      serve(32'hAABBCCDD, 0);
      checks++; if (ld_resp_data !== exp[i]) begin failures++; $display("FAIL t4_data_%0d got=%h exp=%h", i, ld_resp_data, exp[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_flush;
    flush = 1'b1;
    ld_req_valid = 1'b1; ld_req_addr = 32'h600; ld_req_size = 2'd2;
    st_req_valid = 1'b1; st_req_addr = 32'h500; st_req_size = 2'd2; st_req_data = 32'h0BAD;
    #1;
    checks++; if ({st_req_ready, ld_req_ready} !== 2'b10) begin failures++; $display("FAIL t5_idle_flush got=%b exp=10", {st_req_ready, ld_req_ready}); end
    @(negedge clk);
    flush = 1'b0; st_req_valid = 1'b0;
    #1;
    serve(32'h0, 0);
    checks++; if (st_done !== 1'b1) begin failures++; $display("FAIL t5_st_done got=%0b exp=1", st_done); end
    @(negedge clk);
    @(negedge clk);
    ld_req_valid = 1'b0;
    m_req_ready = 1'b1;
    @(negedge clk);
    m_req_ready = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    m_resp_valid = 1'b1; m_resp_data = 32'h77;
    @(negedge clk);
    m_resp_valid = 1'b0;
    #1;
    checks++; if (ld_resp_valid !== 1'b0) begin failures++; $display("FAIL t5_squash_resp got=%0b exp=0", ld_resp_valid); end
    @(negedge clk);
    ld_req_valid = 1'b1; ld_req_addr = 32'h700;
    #1;
    checks++; if ({ld_req_ready, ld_resp_valid} !== 2'b10) begin failures++; $display("FAIL t5_next_grant got=%b exp=10", {ld_req_ready, ld_resp_valid}); end
    @(negedge clk);
    ld_req_valid = 1'b0;
    #1;
    serve(32'h88, 0);
    checks++; if ({ld_resp_valid, ld_resp_data} !== {1'b1, 32'h88}) begin failures++; $display("FAIL t5_after_flush got=%b/%h exp=1/00000088", ld_resp_valid, ld_resp_data); end
    @(negedge clk);
  endtask

  task automatic test_rdy_and_rst;
    st_req_valid = 1'b1; st_req_addr = 32'h3000; st_req_size = 2'd1; st_req_data = 32'h12345678;
    @(negedge clk);
    st_req_valid = 1'b0; rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({m_req_valid, m_req_wr, m_req_size, m_req_addr, m_req_wdata} !== {2'b11, 2'd1, 32'h3000, 32'h12345678}) begin
        failures++; $display("FAIL t6_frozen_%0d got=%0b/%h/%h exp=1/00003000/12345678", i, m_req_valid, m_req_addr, m_req_wdata); end
      @(negedge clk);
    end
    rdy = 1'b1;
    #1;
    serve(32'h0, 0);
    checks++; if (st_done !== 1'b1) begin failures++; $display("FAIL t6_resume_done got=%0b exp=1", st_done); end
    @(negedge clk);
    rdy = 1'b0; st_req_valid = 1'b1;
    #1;
    checks++; if (st_req_ready !== 1'b0) begin failures++; $display("FAIL t6_rdy_low_ready got=%0b exp=0", st_req_ready); end
    st_req_valid = 1'b0; rdy = 1'b1;
    if_req_valid = 1'b1; if_req_addr = 32'h900;
    @(negedge clk);
    if_req_valid = 1'b0; m_req_ready = 1'b1;
    @(negedge clk);
    m_req_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    #1;
    checks++; if ({m_req_valid, m_req_wr, m_req_size, if_resp_valid, ld_resp_valid, st_done} !== 7'd0 || m_req_addr !== 32'h0 || ld_resp_data !== 32'h0) begin
      failures++; $display("FAIL t6_rst_outputs got=%0b/%h/%h exp=0/0/0", m_req_valid, m_req_addr, ld_resp_data); end
    rst = 1'b0;
    if_req_valid = 1'b1;
    #1;
    checks++; if (if_req_ready !== 1'b1) begin failures++; $display("FAIL t6_idle_after_rst got=%0b exp=1", if_req_ready); end
    if_req_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_if_only();
    test_priority();
    test_starvation();
    test_sizes();
    test_flush();
    test_rdy_and_rst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
